// File: rtl/s8ddf_bit.sv
// Single-bit D flop with asynchronous active-low reset (r) and set (s).
// Reset dominates set; qn is the combinational complement of q.
module s8ddf_bit (
    input  logic clk,
    input  logic r,
    input  logic s,
    input  logic d,
    output logic q,
    output logic qn
);

    // The set is masked while reset is low. Releasing r with s still low
    // makes set_n fall, so the flop moves to 1 at once instead of waiting
    // for a clock edge. It also keeps an unknown s out of the flop during reset.
    logic set_n;

    assign set_n = s | ~r;

    always_ff @(posedge clk or negedge r or negedge set_n) begin
        if (!r) begin
            q <= 1'b0;
        end else if (!set_n) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/s8ddf.sv
// WIDTH-bit register of independent s8ddf_bit flops.
// All bits share clk and the asynchronous active-low reset r and set s.
module s8ddf #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        s8ddf_bit u_bit (
            .clk (clk),
            .r   (r),
            .s   (s),
            .d   (d[i]),
            .q   (q[i]),
            .qn  (qn[i])
        );
    end

endmodule

// File: tb/tb_s8ddf.sv
// Directed bench for s8ddf with a 1-bit and an 8-bit instance.
// Both instances share clk, r and s.
`timescale 1ns/1ps
module tb_s8ddf;

    logic       clk = 1'b0;
    logic       r;
    logic       s;
    logic [0:0] d1;
    logic [0:0] q1;
    logic [0:0] qn1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;

    int vectors = 0;
    int miscompares = 0;

    s8ddf #(.WIDTH(1)) dut1 (
        .clk (clk),
        .r   (r),
        .s   (s),
        .d   (d1),
        .q   (q1),
        .qn  (qn1)
    );

    s8ddf #(.WIDTH(8)) dut8 (
        .clk (clk),
        .r   (r),
        .s   (s),
        .d   (d8),
        .q   (q8),
        .qn  (qn8)
    );

    // Rising edges at 50, 150, 250, ... ns
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e1, input logic [7:0] e8);
        chk({tag, ".q1"},  {7'd0, q1},  {7'd0, e1});
        chk({tag, ".qn1"}, {7'd0, qn1}, {7'd0, ~e1});
        chk({tag, ".q8"},  q8,  e8);
        chk({tag, ".qn8"}, qn8, ~e8);
    endtask

    initial begin
        // Reset asserted from time 0 with d high and the clock running
        r  = 1'b0;
        s  = 1'b1;
        d1 = 1'b1;
        d8 = 8'hA5;
        #5;
        chk_all("reset_no_edge", 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_with_edges", 1'b0, 8'h00);

        // Release reset mid-cycle: the value holds until the next edge
        #20;
        r = 1'b1;
        #1;
        chk_all("reset_release_hold", 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk_all("capture_a5", 1'b1, 8'hA5);

        // Data change between edges has no effect; the next edge loads it
        d1 = 1'b0;
        d8 = 8'h3C;
        #10;
        chk_all("d_change_no_edge", 1'b1, 8'hA5);
        @(posedge clk);
        #1;
        chk_all("capture_3c", 1'b0, 8'h3C);

        // Glitch on d between two edges
        #10;
        d1 = 1'b1;
        d8 = 8'hFF;
        #10;
        d1 = 1'b0;
        d8 = 8'h3C;
        #1;
        chk_all("glitch_mid", 1'b0, 8'h3C);
        @(posedge clk);
        #1;
        chk_all("glitch_after_edge", 1'b0, 8'h3C);

        // Asynchronous set mid-cycle; d=0 ignored on following edges
        d8 = 8'h00;
        #20;
        s = 1'b0;
        #1;
        chk_all("async_set", 1'b1, 8'hFF);
        @(posedge clk);
        #1;
        chk_all("set_held_edge", 1'b1, 8'hFF);

        // Reset and set together: reset dominates
        #10;
        r = 1'b0;
        #1;
        chk_all("both_asserted", 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk_all("both_asserted_edge", 1'b0, 8'h00);

        // Release reset with set held: switches to ones immediately
        #10;
        r = 1'b1;
        #1;
        chk_all("r_release_s_low", 1'b1, 8'hFF);
        @(posedge clk);
        #1;
        chk_all("s_low_edge", 1'b1, 8'hFF);

        // Release set: holds ones until the next edge, which loads d
        d1 = 1'b0;
        d8 = 8'h5A;
        #10;
        s = 1'b1;
        #1;
        chk_all("s_release_hold", 1'b1, 8'hFF);
        @(posedge clk);
        #1;
        chk_all("capture_after_set", 1'b0, 8'h5A);

        // Unknown set while reset is low stays deterministic
        #10;
        r = 1'b0;
        #1;
        s = 1'bx;
        #1;
        chk_all("s_x_under_reset", 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk_all("s_x_under_reset_edge", 1'b0, 8'h00);
        s = 1'b1;
        #10;
        r = 1'b1;

        // Load a pattern, then reset mid-operation
        d1 = 1'b1;
        d8 = 8'hC3;
        @(posedge clk);
        #1;
        chk_all("capture_c3", 1'b1, 8'hC3);
        #20;
        r = 1'b0;
        #1;
        chk_all("mid_op_reset", 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk_all("mid_op_reset_edge", 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/s8ddf.md
S8DDF -- requirements
Module: s8ddf

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of d, q and qn; legal range 1..64.
REQ-002 Port: clk  input  1  single clock; all synchronous activity on the rising edge.
REQ-003 Port: r  input  1  reset, asynchronous and active-low; r=0 clears the register.
REQ-004 Port: s  input  1  set, asynchronous and active-low; s=0 presets the register.
REQ-005 Port: d  input  WIDTH  data captured on the rising clk edge.
REQ-006 Port: q  output  WIDTH  registered data.
REQ-007 Port: qn  output  WIDTH  bitwise complement of q.
REQ-008 The block SHALL use one clock (clk); reset r SHALL be asynchronous and active-low.

Function
REQ-009 With r=1 and s=1, the block SHALL load q from d on every rising clk edge, one-edge latency, no enable.
REQ-010 When r=0, q SHALL go to all-zeros immediately, independent of clk, d and s.
REQ-011 When s=0 and r=1, q SHALL go to all-ones immediately, independent of clk and d.
REQ-012 When r=0 and s=0 together, reset SHALL dominate: q=all-zeros, qn=all-ones.
REQ-013 qn SHALL equal ~q at all times, including during reset, set and both asserted; never q==qn.
REQ-014 While r=0 or s=0, clk edges SHALL have no effect; d is ignored.
REQ-015 After r or s deasserts, q SHALL hold its forced value until the next rising clk edge with r=1 and s=1, which loads d.
REQ-016 When r deasserts while s=0, q SHALL switch immediately from all-zeros to all-ones.
REQ-017 d changes between clock edges SHALL NOT affect q; q changes only on a rising clk edge or on r/s assertion.
REQ-018 All WIDTH bits SHALL behave identically and independently; no cross-bit logic.
REQ-019 An X or Z on s with r=0 SHALL NOT disturb q; reset dominance makes the output deterministic.

Reset
REQ-020 Reset value: q=all-zeros, qn=all-ones.
REQ-021 Reset assertion SHALL take effect asynchronously, without waiting for a clock edge.
REQ-022 Reset deassertion SHALL take effect at the next rising clk edge; no internal synchronizer.
REQ-023 No other state exists; a mid-operation reset fully restores the reset state.

Structure
REQ-024 No shared package is required; WIDTH is the only constant and is local to the module.
REQ-025 One sub-module is natural: s8ddf_bit, a 1-bit flop with async active-low r and s and q/qn outputs.
REQ-026 The top SHALL instantiate s8ddf_bit WIDTH times via a generate loop, sharing clk, r and s.
REQ-027 The flop SHALL be inferred from a single always block sensitive to posedge clk, negedge r and negedge s, with r tested first.
REQ-028 qn SHALL be driven combinationally from q, not as a separate register.

Verification
REQ-029 Reset: r=0, s=1, d=1, clk toggling -> q=0, qn=1 throughout, with no clk edge needed.
REQ-030 Capture: r=1, s=1; d=1 at 200 ns -> q=1, qn=0 after the next rising clk; d=0 at 900 ns -> q=0 after the following edge.
REQ-031 Async set: r=1; s 1->0 mid-cycle -> q=1, qn=0 within the same delta cycle, with d=0 ignored on clk edges.
REQ-032 Priority: r=0 and s=0 -> q=0, qn=1; release r with s=0 held -> q=1 immediately; release s -> q follows d at the next edge.
REQ-033 Glitch: with r=s=1, d pulses 0->1->0 between two rising edges -> q unchanged.
REQ-034 Width: WIDTH=8, d=8'hA5 with r=s=1 -> q=8'hA5, qn=8'h5A after one edge; r=0 -> q=8'h00, qn=8'hFF.
